// File: rtl/div_wb_merger_pkg.sv
// Shared types and default sizing for the divider write-back merger.
// The optional WAW kill feature is enabled by defining DIV_WB_WAW_KILL_EN.
package div_wb_merger_pkg;

    localparam int DIV_WB_DEPTH   = 4;
    localparam int MULT_PPL_STAGE = 2;

    typedef enum logic {
        DIV_WB_SRC_PIPE = 1'b0,
        DIV_WB_SRC_DIV  = 1'b1
    } wb_src_e;

    typedef struct packed {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/div_wb_fifo.sv
// In-order result buffer for divider write-backs that lost port arbitration.
// Entries can be invalidated in place (kill) while still occupying their slot.
module div_wb_fifo
    import div_wb_merger_pkg::*;
#(
    parameter int DEPTH = DIV_WB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [4:0]            push_addr,
    input  logic [31:0]           push_data,
    input  logic                  pop,
    input  logic                  kill,
    input  logic [4:0]            kill_addr,
    output wb_entry_t             head,
    output logic [PW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [DEPTH-1:0][4:0] ent_addr
);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    // Kill, then pop-clear, then push: a push into the slot freed by a pop wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && mem[i].addr == kill_addr) begin
                    mem[i].valid <= 1'b0;
                end
            end
            if (pop) begin
                mem[rd_ptr].valid <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= '{valid: 1'b1, addr: push_addr, data: push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW + 1)'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        ent_valid = '0;
        ent_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = mem[i].valid;
            ent_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/div_wb_merger.sv
// Merges divider results with the main pipeline write onto one register-file port.
// Define DIV_WB_WAW_KILL_EN to let pipeline writes invalidate stale buffered results.
module div_wb_merger
    import div_wb_merger_pkg::*;
#(
    parameter int DEPTH     = DIV_WB_DEPTH,
    parameter int PPL_STAGE = MULT_PPL_STAGE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  div_rd_addr_i,
    input  logic [31:0] div_rd_data_i,
    input  logic        pipe_we_i,
    input  logic [4:0]  pipe_rd_addr_i,
    input  logic [31:0] pipe_rd_data_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        div_hold_o,
    output logic [31:0] pend_flags_o,
    output logic        ovf_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                  pipe_v;
    logic                  div_v;
    logic                  pop;
    logic                  bypass;
    logic                  push_req;
    logic                  push;
    logic                  kill;
    wb_entry_t             head;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0][4:0] ent_addr;

    logic                  next_we;
    logic [4:0]            next_addr;
    logic [31:0]           next_data;
    wb_src_e               next_src;
    wb_src_e               out_src;

    assign pipe_v   = pipe_we_i && (pipe_rd_addr_i != 5'd0);
    assign div_v    = (div_rd_addr_i != 5'd0);
    assign pop      = !pipe_v && !empty;
    assign bypass   = !pipe_v && empty && div_v;
    assign push_req = div_v && !bypass;
    assign push     = push_req && (!full || pop);

`ifdef DIV_WB_WAW_KILL_EN
    assign kill = pipe_v;
`else
    assign kill = 1'b0;
`endif

    div_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (div_rd_addr_i),
        .push_data (div_rd_data_i),
        .pop       (pop),
        .kill      (kill),
        .kill_addr (pipe_rd_addr_i),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    // Port arbitration: pipeline first, then buffered head, then bypass.
    always_comb begin
        next_we   = 1'b0;
        next_addr = 5'd0;
        next_data = 32'd0;
        next_src  = DIV_WB_SRC_PIPE;
        if (pipe_v) begin
            next_we   = 1'b1;
            next_addr = pipe_rd_addr_i;
            next_data = pipe_rd_data_i;
        end else if (pop) begin
            next_we   = head.valid;
            next_addr = head.addr;
            next_data = head.data;
            next_src  = DIV_WB_SRC_DIV;
        end else if (bypass) begin
            next_we   = 1'b1;
            next_addr = div_rd_addr_i;
            next_data = div_rd_data_i;
            next_src  = DIV_WB_SRC_DIV;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_o    <= 1'b0;
            rf_waddr_o <= 5'd0;
            rf_wdata_o <= 32'd0;
            out_src    <= DIV_WB_SRC_PIPE;
            ovf_o      <= 1'b0;
        end else begin
            rf_we_o    <= next_we;
            rf_waddr_o <= next_addr;
            rf_wdata_o <= next_data;
            out_src    <= next_src;
            if (push_req && full && !pop) begin
                ovf_o <= 1'b1;
            end
        end
    end

    always_comb begin
        pend_flags_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pend_flags_o[ent_addr[i]] = 1'b1;
            end
        end
        if (rf_we_o && out_src == DIV_WB_SRC_DIV) begin
            pend_flags_o[rf_waddr_o] = 1'b1;
        end
        pend_flags_o[0] = 1'b0;
    end

    assign div_hold_o = (DEPTH - int'(count)) < PPL_STAGE;

endmodule

// File: tb/tb_div_wb_merger.sv
// Randomized and directed bench for div_wb_merger against a queue-based reference model.
// The model honours DIV_WB_WAW_KILL_EN the same way the design build does.
module tb_div_wb_merger;
    import div_wb_merger_pkg::*;

    localparam int DEPTH = DIV_WB_DEPTH;
    localparam int PPL   = MULT_PPL_STAGE;

    logic        clk;
    logic        rst_n;
    logic [4:0]  div_rd_addr_i;
    logic [31:0] div_rd_data_i;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_addr_i;
    logic [31:0] pipe_rd_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        div_hold_o;
    logic [31:0] pend_flags_o;
    logic        ovf_o;

    div_wb_merger dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .div_rd_addr_i  (div_rd_addr_i),
        .div_rd_data_i  (div_rd_data_i),
        .pipe_we_i      (pipe_we_i),
        .pipe_rd_addr_i (pipe_rd_addr_i),
        .pipe_rd_data_i (pipe_rd_data_i),
        .rf_we_o        (rf_we_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o),
        .div_hold_o     (div_hold_o),
        .pend_flags_o   (pend_flags_o),
        .ovf_o          (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [4:0]  a;
        bit [31:0] d;
    } ent_t;

    ent_t      m_q[$];
    bit        m_we;
    bit [4:0]  m_addr;
    bit [31:0] m_data;
    bit        m_from_div;
    bit        m_ovf;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_q.delete();
        m_we = 0; m_addr = 0; m_data = 0; m_from_div = 0; m_ovf = 0;
    endtask

    // One clock of the reference behaviour, using the rules directly on a queue.
    task automatic modelStep(input bit pwe, input bit [4:0] pa, input bit [31:0] pd,
                             input bit [4:0] da, input bit [31:0] dd);
        bit   pv, dv, taken;
        ent_t e;
        pv = pwe && (pa != 0);
        dv = (da != 0);
        taken = 0;
        m_we = 0; m_addr = 0; m_data = 0; m_from_div = 0;
        if (pv) begin
            m_we = 1; m_addr = pa; m_data = pd;
`ifdef DIV_WB_WAW_KILL_EN
            foreach (m_q[i]) if (m_q[i].a == pa) m_q[i].v = 0;
`endif
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = e.v; m_addr = e.a; m_data = e.d; m_from_div = 1;
        end else if (dv) begin
            m_we = 1; m_addr = da; m_data = dd; m_from_div = 1;
            taken = 1;
        end
        if (dv && !taken) begin
            if (m_q.size() < DEPTH) begin
                e.v = 1; e.a = da; e.d = dd;
                m_q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic checkAll();
        bit [31:0] flags;
        flags = 0;
        foreach (m_q[i]) if (m_q[i].v) flags[m_q[i].a] = 1;
        if (m_we && m_from_div) flags[m_addr] = 1;
        flags[0] = 0;
        checkOutput("rf_we", {31'd0, rf_we_o}, {31'd0, m_we});
        if (m_we) begin
            checkOutput("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, m_addr});
            checkOutput("rf_wdata", rf_wdata_o, m_data);
        end
        checkOutput("div_hold", {31'd0, div_hold_o}, {31'd0, ((DEPTH - m_q.size()) < PPL)});
        checkOutput("pend_flags", pend_flags_o, flags);
        checkOutput("ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
    endtask

    // Drive one cycle of inputs (called just after a rising edge), then check after the next edge.
    task automatic applyStimulus(input bit pwe, input bit [4:0] pa, input bit [31:0] pd,
                                 input bit [4:0] da, input bit [31:0] dd);
        pipe_we_i = pwe; pipe_rd_addr_i = pa; pipe_rd_data_i = pd;
        div_rd_addr_i = da; div_rd_data_i = dd;
        modelStep(pwe, pa, pd, da, dd);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic asyncReset();
        #3;
        rst_n = 1'b0;
        pipe_we_i = 0; pipe_rd_addr_i = 0; pipe_rd_data_i = 0;
        div_rd_addr_i = 0; div_rd_data_i = 0;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
        checkOutput("rst_wdata", rf_wdata_o, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pipe_we_i = 0; pipe_rd_addr_i = 0; pipe_rd_data_i = 0;
        div_rd_addr_i = 0; div_rd_data_i = 0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        checkOutput("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
        checkOutput("rst_wdata", rf_wdata_o, 32'd0);
        rst_n = 1'b1;

        // Idle, then a single bypassed divider result.
        idle(1);
        applyStimulus(0, 0, 0, 5'd5, 32'h1234);
        checkOutput("bypass_we", {31'd0, rf_we_o}, 32'd1);
        checkOutput("bypass_addr", {27'd0, rf_waddr_o}, 32'd5);
        checkOutput("bypass_data", rf_wdata_o, 32'h1234);
        idle(1);

        // Pipeline and divider in the same cycle: divider waits one cycle.
        applyStimulus(1, 5'd3, 32'hAA, 5'd7, 32'hBB);
        checkOutput("pend7_c1", {31'd0, pend_flags_o[7]}, 32'd1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("drain_x7", {27'd0, rf_waddr_o}, 32'd7);
        checkOutput("pend7_c2", {31'd0, pend_flags_o[7]}, 32'd1);
        idle(1);
        checkOutput("pend7_c3", {31'd0, pend_flags_o[7]}, 32'd0);

        // Fill to DEPTH under pipeline pressure, then simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1, 5'd1, 32'h100 + i, 5'(10 + i), 32'h200 + i);
        checkOutput("full_hold", {31'd0, div_hold_o}, 32'd1);
        applyStimulus(0, 0, 0, 5'd20, 32'h300);
        checkOutput("pushpop_ovf", {31'd0, ovf_o}, 32'd0);
        checkOutput("pushpop_head", {27'd0, rf_waddr_o}, 32'd10);
        idle(DEPTH + 2);

        // WAW: x9 buffered, then a pipeline write to x9.
        applyStimulus(1, 5'd2, 32'h22, 5'd9, 32'h999);
        applyStimulus(1, 5'd9, 32'h9A9A, 0, 0);
        idle(3);

        // Overflow: a fifth result while full and blocked is dropped.
        for (int i = 0; i < DEPTH + 1; i++)
            applyStimulus(1, 5'd4, 32'h40 + i, 5'(16 + i), 32'h500 + i);
        checkOutput("ovf_set", {31'd0, ovf_o}, 32'd1);
        idle(DEPTH + 2);

        // Asynchronous reset with three results buffered.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 5'd6, 32'h60 + i, 5'(24 + i), 32'h700 + i);
        asyncReset();
        idle(5);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            bit        pwe;
            bit [4:0]  pa, da;
            pwe = ($urandom_range(0, 1) == 1);
            pa  = 5'($urandom_range(0, 15));
            da  = ($urandom_range(0, 9) < 4) ? 5'($urandom_range(1, 15)) : 5'd0;
            applyStimulus(pwe, pa, $urandom, da, $urandom);
            if (i % 150 == 149) asyncReset();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
